// File: rtl/ifm_enc_pkg.sv
// Shared types, sizes and helpers for the IFM sparse chunk encoder.
// BUS_SIZE / MEM_SIZE come from macros of the same name (defaults 8 / 32).
`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 32
`endif

package ifm_enc_pkg;

  localparam int BUS_SIZE       = `BUS_SIZE;
  localparam int MEM_SIZE       = `MEM_SIZE;
  localparam int WR_DAT_CYC_NUM = MEM_SIZE / BUS_SIZE;
  localparam int CNT_W          = $clog2(WR_DAT_CYC_NUM);
  localparam int POP_W          = $clog2(BUS_SIZE) + 1;
  localparam int NZ_W           = $clog2(MEM_SIZE) + 1;

  typedef enum logic {
    S_WAIT,
    S_FILL
  } state_e;

  function automatic logic [POP_W-1:0] popcount_bus(
    input logic [BUS_SIZE-1:0] m
  );
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < BUS_SIZE; i++)
      c = c + POP_W'(m[i]);
    return c;
  endfunction

endpackage

// File: rtl/ifm_beat_compactor.sv
// Combinational per-beat sparsemap build and nonzero-byte compaction.
// Each set byte is steered to the slot given by the prefix count below it.
module ifm_beat_compactor
  import ifm_enc_pkg::*;
(
  input  logic [BUS_SIZE*8-1:0] beat,
  output logic [BUS_SIZE-1:0]   smap,
  output logic [BUS_SIZE*8-1:0] cdata
);

  always_comb begin
    smap = '0;
    for (int j = 0; j < BUS_SIZE; j++)
      smap[j] = |beat[j*8 +: 8];
  end

  always_comb begin
    int p;
    cdata = '0;
    p = 0;
    for (int j = 0; j < BUS_SIZE; j++) begin
      if (smap[j])
        cdata[p*8 +: 8] = beat[j*8 +: 8];
      p = p + int'(smap[j]);
    end
  end

endmodule

// File: rtl/ifm_chunk_sparse_encoder.sv
// Dense-to-sparse IFM chunk writer with ping-pong buffer ownership.
// Optional IFM_ENC_NZ_COUNT_EN adds the per-chunk nonzero byte count.
module ifm_chunk_sparse_encoder
  import ifm_enc_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [BUS_SIZE*8-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  wr_valid_o,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic                  wr_sel_o,
  input  logic [1:0]            buf_release_i,
`ifdef IFM_ENC_NZ_COUNT_EN
  output logic [NZ_W-1:0]       chunk_nz_cnt_o,
`endif
  output logic [1:0]            buf_full_o,
  output logic                  chunk_done_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WR_DAT_CYC_NUM - 1);

  state_e                  state;
  logic                    sel;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              buf_full;
  logic [1:0]              buf_full_nxt;
  logic [BUS_SIZE-1:0]     smap;
  logic [BUS_SIZE*8-1:0]   cdata;
  logic                    accept;
  logic                    last;

  ifm_beat_compactor u_cmp (
    .beat  (in_data_i),
    .smap  (smap),
    .cdata (cdata)
  );

  assign in_ready_o = (state == S_FILL);
  assign accept     = in_valid_i && in_ready_o;
  assign last       = accept && (cnt == LAST);
  assign buf_full_o = buf_full;

  // Set wins over a same-cycle release of the buffer just completed.
  always_comb begin
    buf_full_nxt = buf_full & ~buf_release_i;
    if (last)
      buf_full_nxt[sel] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= S_WAIT;
      sel               <= 1'b0;
      cnt               <= '0;
      buf_full          <= '0;
      wr_valid_o        <= 1'b0;
      chunk_done_o      <= 1'b0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      wr_count_o        <= '0;
      wr_sel_o          <= 1'b0;
    end else begin
      wr_valid_o   <= accept;
      chunk_done_o <= last;
      buf_full     <= buf_full_nxt;
      if (accept) begin
        wr_sparsemap_o    <= smap;
        wr_nonzero_data_o <= cdata;
        wr_count_o        <= cnt;
        wr_sel_o          <= sel;
        cnt               <= cnt + CNT_W'(1);
      end
      unique case (state)
        S_WAIT: begin
          if (!buf_full[sel] || buf_release_i[sel])
            state <= S_FILL;
        end
        S_FILL: begin
          if (last) begin
            state <= S_WAIT;
            sel   <= ~sel;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

`ifdef IFM_ENC_NZ_COUNT_EN
  logic [NZ_W-1:0] nz_acc;
  logic [NZ_W-1:0] nz_sum;

  assign nz_sum = ((cnt == '0) ? '0 : nz_acc)
                + NZ_W'(popcount_bus(smap));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nz_acc         <= '0;
      chunk_nz_cnt_o <= '0;
    end else if (accept) begin
      nz_acc <= nz_sum;
      if (last)
        chunk_nz_cnt_o <= nz_sum;
    end
  end
`endif

  a_no_release_on_set: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(last && buf_release_i[sel])
  );

endmodule

// File: tb/tb_ifm_chunk_sparse_encoder.sv
// Directed bench for ifm_chunk_sparse_encoder (BUS_SIZE=8, MEM_SIZE=32).
// Optional nonzero-count checks follow IFM_ENC_NZ_COUNT_EN.
module tb_ifm_chunk_sparse_encoder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  smap;
  logic [63:0] nzd;
  logic        wr_valid;
  logic [1:0]  wr_count;
  logic        wr_sel;
  logic [1:0]  rel;
  logic [1:0]  buf_full;
  logic        done;
`ifdef IFM_ENC_NZ_COUNT_EN
  logic [5:0]  nz_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  ifm_chunk_sparse_encoder dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .in_data_i         (in_data),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .wr_sparsemap_o    (smap),
    .wr_nonzero_data_o (nzd),
    .wr_valid_o        (wr_valid),
    .wr_count_o        (wr_count),
    .wr_sel_o          (wr_sel),
    .buf_release_i     (rel),
`ifdef IFM_ENC_NZ_COUNT_EN
    .chunk_nz_cnt_o    (nz_cnt),
`endif
    .buf_full_o        (buf_full),
    .chunk_done_o      (done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [63:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 4) begin
      step();
      n++;
    end
    chk(tag, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_ni   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    rel      = '0;
    step();
    step();
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(wr_valid), 64'd0);
    chk("rst_full",  64'(buf_full), 64'd0);
    chk("rst_smap",  64'(smap), 64'd0);
    chk("rst_data",  nzd, 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    rst_ni = 1'b1;
    wait_ready("ready0");

    // chunk 0 into buffer 0
    send(64'h0009_0000_0700_0500);
    chk("b0_valid", 64'(wr_valid), 64'd1);
    chk("b0_smap",  64'(smap), 64'h4A);
    chk("b0_data",  nzd, 64'h0000_0000_0009_0705);
    chk("b0_cnt",   64'(wr_count), 64'd0);
    chk("b0_sel",   64'(wr_sel), 64'd0);
    chk("b0_done",  64'(done), 64'd0);
    send(64'h0);
    chk("zero_smap", 64'(smap), 64'h0);
    chk("zero_data", nzd, 64'h0);
    chk("b1_cnt",    64'(wr_count), 64'd1);
    send(64'h0807_0605_0403_0201);
    chk("full_smap", 64'(smap), 64'hFF);
    chk("full_data", nzd, 64'h0807_0605_0403_0201);
    chk("b2_cnt",    64'(wr_count), 64'd2);
    chk("b2_done",   64'(done), 64'd0);
    send(64'h0A00_0000_0000_0000);
    chk("b3_smap",  64'(smap), 64'h80);
    chk("b3_data",  nzd, 64'h0A);
    chk("b3_cnt",   64'(wr_count), 64'd3);
    chk("b3_done",  64'(done), 64'd1);
    chk("b3_full",  64'(buf_full), 64'b01);
    chk("b3_ready", 64'(in_ready), 64'd0);
`ifdef IFM_ENC_NZ_COUNT_EN
    chk("nz_cnt12", 64'(nz_cnt), 64'd12);
`endif

    // valid held while not ready: nothing written, data held
    in_valid = 1'b1;
    in_data  = 64'h1111_1111_1111_1111;
    step();
    chk("hold_valid", 64'(wr_valid), 64'd0);
    chk("hold_done",  64'(done), 64'd0);
    chk("hold_smap",  64'(smap), 64'h80);
    in_valid = 1'b0;
    wait_ready("ready1");

    // chunk 1 into buffer 1
    for (int i = 0; i < 4; i++) begin
      send(64'(i + 1));
      chk("c1_sel",  64'(wr_sel), 64'd1);
      chk("c1_cnt",  64'(wr_count), 64'(i));
      chk("c1_data", nzd, 64'(i + 1));
    end
    chk("c1_done", 64'(done), 64'd1);
    chk("c1_full", 64'(buf_full), 64'b11);

    // both full: stall
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(wr_valid), 64'd0);
    end
    in_valid = 1'b0;
    rel = 2'b01;
    step();
    rel = 2'b00;
    wait_ready("rel_ready");
    chk("rel_full", 64'(buf_full), 64'b10);

    // chunk 2 into buffer 0; release buffer 1 with the last beat
    send(64'h0000_0000_0000_0042);
    chk("c2_sel", 64'(wr_sel), 64'd0);
    chk("c2_cnt", 64'(wr_count), 64'd0);
    send(64'h0000_0000_0000_0042);
    send(64'h0000_0000_0000_0042);
    rel = 2'b10;
    send(64'h0000_0000_0000_0042);
    rel = 2'b00;
    chk("c2_done", 64'(done), 64'd1);
    chk("c2_full", 64'(buf_full), 64'b01);

    // partial chunk 3 into buffer 1, then reset
    wait_ready("ready3");
    send(64'h5500);
    chk("c3_sel", 64'(wr_sel), 64'd1);
    send(64'h5500);
    send(64'h5500);
    chk("c3_cnt", 64'(wr_count), 64'd2);
    rst_ni = 1'b0;
    #1;
    chk("ar_valid", 64'(wr_valid), 64'd0);
    chk("ar_cnt",   64'(wr_count), 64'd0);
    chk("ar_sel",   64'(wr_sel), 64'd0);
    chk("ar_smap",  64'(smap), 64'd0);
    chk("ar_data",  nzd, 64'd0);
    chk("ar_full",  64'(buf_full), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd0);
`ifdef IFM_ENC_NZ_COUNT_EN
    chk("ar_nz", 64'(nz_cnt), 64'd0);
`endif
    step();
    rst_ni = 1'b1;
    wait_ready("ready4");
    send(64'h0000_0000_0000_3300);
    chk("pr_smap", 64'(smap), 64'h02);
    chk("pr_data", nzd, 64'h33);
    chk("pr_cnt",  64'(wr_count), 64'd0);
    chk("pr_sel",  64'(wr_sel), 64'd0);
    chk("pr_full", 64'(buf_full), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
